isp_ccm_ctrl: RTL
=================

// Module: isp_ccm_ctrl
// PURPOSE
//  Configuration controller for the colour-correction-matrix stage: holds the nine S4.4 coefficients
//  and a bypass flag in a host-writable shadow bank, and copies them to the active bank only at a
//  frame boundary (rising edge of in_vsync), so a frame is never processed with a mixed matrix.
//  Sits between the host register bus and the CCM datapath's m_* inputs, in the pclk domain.
// PARAMETERS
//  ADDR_BITS  4  register address width; map below uses addresses 0..10
// PORTS
//  pclk         in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  in_vsync     in   1   frame sync seen by the CCM datapath, active high
//  reg_we       in   1   write strobe, one-cycle
//  reg_re       in   1   read strobe, one-cycle
//  reg_addr     in   ADDR_BITS register address
//  reg_wdata    in   8   write data
//  reg_rdata    out  8   read data, registered
//  m_rr..m_bb   out  8x9 signed S4.4 active coefficients (m_rr,m_rg,m_rb,m_gr,m_gg,m_gb,m_br,m_bg,m_bb)
//  pending      out  1   commit requested, not yet applied
//  apply_pulse  out  1   one-cycle pulse, high in the cycle the active bank updates
//  frame_cnt    out  16  frames seen (vsync rising edges), wraps 0xFFFF->0
// BEHAVIOUR
//  Register map:
//   - 0..8  shadow coefficients, in m_* order above; read/write.
//   - 9     CTRL: write bit0=1 requests commit (self-clearing); bit1 = shadow bypass.
//           Read: {6'b0, shadow_bypass, pending}.
//   - 10    STATUS, read-only: {6'b0, active_bypass, 1'b0}.
//   - Other addresses: writes ignored, reads return 0.
//  Reset values:
//   - Shadow and active coefficients = identity: rr/gg/bb = 8'sh10, all others 0.
//   - Bypass bits 0, pending 0, apply_pulse 0, frame_cnt 0, reg_rdata 0, vsync edge register 0.
//  Edge detect: register in_vsync once. A frame boundary fb is asserted in the cycle where
//   in_vsync=1 and the registered copy is 0.
//  Two-state FSM:
//   - IDLE -> PEND on a CTRL write with bit0=1.
//   - PEND -> IDLE on fb. In that cycle active<=shadow for all coefficients and bypass, and
//     apply_pulse goes high on the next clock edge.
//   - pending = (state==PEND).
//   - Active bank changes only on an fb that occurs while in PEND.
//  Output mapping: m_* = active_bypass ? identity : active coefficients. The outputs are driven
//   directly from registers and are stable for the whole frame.
//  frame_cnt increments on every fb, whether or not a commit is pending.
//  Read latency: reg_rdata is updated 1 cycle after reg_re and holds its value until the next read.
//  Simultaneous events:
//   - Shadow write in the same cycle as an applying fb: active takes the pre-write shadow value,
//     the write lands in shadow, and pending is cleared.
//   - CTRL commit write in the same cycle as an applying fb: the apply happens and the state stays
//     PEND, so the new commit takes effect at the next fb.
//   - Commit while already PEND: no effect; stays PEND.
//   - CTRL write with bit0=0: updates shadow bypass only.
//  Reset mid-frame: all state returns to the reset values immediately, so the active bank is
//   identity until a commit is applied at a later fb. in_vsync held high through reset does not
//   produce an fb on reset release.
//  Widths: coefficients are stored as raw 8-bit two's complement (S4.4). No saturation or
//   checking is applied.
// TESTING
//  1 Reset: release rst_n -> m_rr=m_gg=m_bb=0x10, others 0, pending=0, frame_cnt=0.
//  2 Write addr0=0x20, addr1=0xF8 (-0.5), then CTRL=0x01 mid-frame:
//    -> pending=1 and m_rr still 0x10.
//    -> One cycle after the next vsync rise: m_rr=0x20, m_rg=0xF8, apply_pulse=1 for exactly
//       1 cycle, pending=0.
//  3 Shadow writes with no commit across 3 vsync rises -> m_* unchanged, frame_cnt=3,
//    apply_pulse never high.
//  4 Shadow matrix non-identity, CTRL=0x03 then fb -> STATUS reads 0x02 and m_* = identity.
//    Then CTRL=0x01 then fb -> non-identity matrix appears.
//  5 Same-cycle cases at an fb while PEND:
//    - addr2 write 0x05 (old shadow 0x00) -> m_rb=0x00, shadow reads 0x05.
//    - CTRL commit in the same cycle -> pending stays 1 and the next fb applies 0x05.
//  6 Assert rst_n low while PEND mid-frame -> identity outputs, pending=0.
//    With in_vsync high during release -> no apply; frame_cnt=0.

Source files
------------

// File: rtl/isp_ccm_ctrl_if.sv
// Host register bus for the CCM configuration controller.
// The host side (master) drives strobes, address and write data; the
// controller side (slave) returns registered read data.
interface isp_ccm_ctrl_if #(
    parameter int ADDR_BITS = 4
) ();
    logic                 reg_we;
    logic                 reg_re;
    logic [ADDR_BITS-1:0] reg_addr;
    logic [7:0]           reg_wdata;
    logic [7:0]           reg_rdata;

    modport master (
        output reg_we,
        output reg_re,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_we,
        input  reg_re,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/isp_ccm_ctrl.sv
// Colour-correction-matrix configuration controller.
// Holds nine S4.4 coefficients plus a bypass flag in a host-writable shadow
// bank and copies them to the active bank only at a frame boundary after a
// commit request, so a frame never sees a partially updated matrix.
module isp_ccm_ctrl #(
    parameter int ADDR_BITS = 4
) (
    input  logic               pclk,
    input  logic               rst_n,
    input  logic               in_vsync,
    isp_ccm_ctrl_if.slave      bus,
    output logic signed [7:0]  m_rr,
    output logic signed [7:0]  m_rg,
    output logic signed [7:0]  m_rb,
    output logic signed [7:0]  m_gr,
    output logic signed [7:0]  m_gg,
    output logic signed [7:0]  m_gb,
    output logic signed [7:0]  m_br,
    output logic signed [7:0]  m_bg,
    output logic signed [7:0]  m_bb,
    output logic               pending,
    output logic               apply_pulse,
    output logic [15:0]        frame_cnt
);

    localparam int                   COEF_CNT    = 9;
    localparam logic [ADDR_BITS-1:0] CTRL_ADDR   = ADDR_BITS'(9);
    localparam logic [ADDR_BITS-1:0] STATUS_ADDR = ADDR_BITS'(10);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Identity matrix entry: unity (1.0 in S4.4) on the diagonal, zero elsewhere.
    function automatic logic [7:0] identity_coef(input int idx);
        if ((idx == 0) || (idx == 4) || (idx == 8)) begin
            return 8'h10;
        end else begin
            return 8'h00;
        end
    endfunction

    state_t      state_r;
    logic        pending_r;
    logic        apply_r;
    logic        vsync_r;
    logic        armed_r;
    logic        shadow_byp_r;
    logic        active_byp_r;
    logic [7:0]  shadow_r [COEF_CNT];
    logic [7:0]  m_r      [COEF_CNT];
    logic [15:0] frame_cnt_r;
    logic [7:0]  rdata_r;
    logic [7:0]  rdata_s;
    logic        ctrl_wr_s;
    logic        commit_s;
    logic        fb_s;

    // armed_r blocks a false boundary when in_vsync is already high as reset
    // releases: a rise only counts once the sync has been seen low.
    assign fb_s      = in_vsync && !vsync_r && armed_r;
    assign ctrl_wr_s = bus.reg_we && (bus.reg_addr == CTRL_ADDR);
    assign commit_s  = ctrl_wr_s && bus.reg_wdata[0];

    // Register the frame sync for rising-edge detection.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            vsync_r <= in_vsync;
            armed_r <= armed_r | ~in_vsync;
        end
    end

    // Count every frame boundary, committed or not.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'h0000;
        end else if (fb_s) begin
            frame_cnt_r <= frame_cnt_r + 16'h0001;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // Host writes into the shadow bank and the shadow bypass flag.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < COEF_CNT; i++) begin
                shadow_r[i] <= identity_coef(i);
            end
            shadow_byp_r <= 1'b0;
        end else begin
            for (int i = 0; i < COEF_CNT; i++) begin
                if (bus.reg_we && (bus.reg_addr == ADDR_BITS'(i))) begin
                    shadow_r[i] <= bus.reg_wdata;
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end
            if (ctrl_wr_s) begin
                shadow_byp_r <= bus.reg_wdata[1];
            end else begin
                shadow_byp_r <= shadow_byp_r;
            end
        end
    end

    // Commit FSM: latch a request, apply shadow to the active outputs at the next boundary.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            pending_r    <= 1'b0;
            apply_r      <= 1'b0;
            active_byp_r <= 1'b0;
            for (int i = 0; i < COEF_CNT; i++) begin
                m_r[i] <= identity_coef(i);
            end
        end else begin
            apply_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (commit_s) begin
                        state_r   <= ST_PEND;
                        pending_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        pending_r <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (fb_s) begin
                        // Non-blocking reads take the pre-write shadow if the
                        // host writes in this same cycle.
                        apply_r      <= 1'b1;
                        active_byp_r <= shadow_byp_r;
                        for (int i = 0; i < COEF_CNT; i++) begin
                            m_r[i] <= shadow_byp_r ? identity_coef(i) : shadow_r[i];
                        end
                        if (commit_s) begin
                            state_r   <= ST_PEND;
                            pending_r <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            pending_r <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_PEND;
                        pending_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    // Read-data selection for the addressed register.
    always_comb begin
        rdata_s = 8'h00;
        case (bus.reg_addr)
            ADDR_BITS'(0): rdata_s = shadow_r[0];
            ADDR_BITS'(1): rdata_s = shadow_r[1];
            ADDR_BITS'(2): rdata_s = shadow_r[2];
            ADDR_BITS'(3): rdata_s = shadow_r[3];
            ADDR_BITS'(4): rdata_s = shadow_r[4];
            ADDR_BITS'(5): rdata_s = shadow_r[5];
            ADDR_BITS'(6): rdata_s = shadow_r[6];
            ADDR_BITS'(7): rdata_s = shadow_r[7];
            ADDR_BITS'(8): rdata_s = shadow_r[8];
            CTRL_ADDR:     rdata_s = {6'b000000, shadow_byp_r, pending_r};
            STATUS_ADDR:   rdata_s = {6'b000000, active_byp_r, 1'b0};
            default:       rdata_s = 8'h00;
        endcase
    end

    // Capture read data one cycle after the strobe and hold it until the next read.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 8'h00;
        end else if (bus.reg_re) begin
            rdata_r <= rdata_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign bus.reg_rdata = rdata_r;
    assign m_rr          = m_r[0];
    assign m_rg          = m_r[1];
    assign m_rb          = m_r[2];
    assign m_gr          = m_r[3];
    assign m_gg          = m_r[4];
    assign m_gb          = m_r[5];
    assign m_br          = m_r[6];
    assign m_bg          = m_r[7];
    assign m_bb          = m_r[8];
    assign pending       = pending_r;
    assign apply_pulse   = apply_r;
    assign frame_cnt     = frame_cnt_r;

endmodule
